mdu_ctrl: RTL

Multi-cycle multiply/divide controller for the execute stage. It accepts one MUL/DIV/DIVU/REM/REMU operation from decode, runs a shared iterative shift-add/shift-subtract datapath for WIDTH cycles, and holds the execute stage frozen through `stall` until the result is ready. Trivial division cases bypass the iteration. The execute stage muxes `result` into its ALU result on `done`.

---
 rtl/mdu_ctrl_pkg.sv | 20 ++
 rtl/mdu_ctrl_iter.sv | 35 +++
 rtl/mdu_ctrl.sv | 117 +++++++++++
 3 files changed

// File: rtl/mdu_ctrl_pkg.sv
// Shared types for the multiply/divide unit: operation codes and controller states.
package mdu_ctrl_pkg;

    localparam int unsigned MDU_OP_W = 3;

    typedef enum logic [MDU_OP_W-1:0] {
        MDU_MUL  = 3'd0,
        MDU_DIV  = 3'd1,
        MDU_DIVU = 3'd2,
        MDU_REM  = 3'd3,
        MDU_REMU = 3'd4
    } mdu_op_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

endpackage

// File: rtl/mdu_ctrl_iter.sv
// One combinational step of the shared datapath on {acc, shreg}: MSB-first
// shift-add for multiply, restoring shift-subtract for divide.
module mdu_iter #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             is_mul,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] shreg,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] acc_next,
    output logic [WIDTH-1:0] shreg_next
);

    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    always_comb begin
        rem_sh     = {acc, shreg[WIDTH-1]};
        diff       = rem_sh - {1'b0, operand};
        acc_next   = '0;
        shreg_next = '0;
        if (is_mul) begin
            // Multiplier bits consumed from shreg MSB; product kept to WIDTH bits.
            acc_next   = {acc[WIDTH-2:0], 1'b0} + (shreg[WIDTH-1] ? operand : '0);
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end else if (!diff[WIDTH]) begin
            acc_next   = diff[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], 1'b1};
        end else begin
            acc_next   = rem_sh[WIDTH-1:0];
            shreg_next = {shreg[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle MUL/DIV/REM controller: FSM, operand/sign registers, trivial-case
// bypass and final sign fix-up around the shared mdu_iter step.
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    mdu_state_t       state;
    mdu_op_t          op_q;
    mdu_op_t          op_in;
    logic [WIDTH-1:0] acc, shreg, operand;
    logic [WIDTH-1:0] acc_next, shreg_next;
    logic [CW-1:0]    count;
    logic             q_neg, r_neg;

    logic             in_div, in_signed, in_quot, div_zero, overflow;
    logic [WIDTH-1:0] a_mag, b_mag, bypass_val, fixed;

    always_comb begin
        op_in      = mdu_op_t'(op);
        in_div     = (op_in != MDU_MUL);
        in_signed  = (op_in == MDU_DIV) || (op_in == MDU_REM);
        in_quot    = (op_in == MDU_DIV) || (op_in == MDU_DIVU);
        a_mag      = (in_signed && a[WIDTH-1]) ? -a : a;
        b_mag      = (in_signed && b[WIDTH-1]) ? -b : b;
        div_zero   = in_div && (b == '0);
        overflow   = in_signed && (a == MIN_NEG) && (b == '1);
        if (div_zero) bypass_val = in_quot ? '1 : a;
        else          bypass_val = in_quot ? a : '0;
    end

    mdu_iter #(.WIDTH(WIDTH)) u_iter (
        .is_mul     (op_q == MDU_MUL),
        .acc        (acc),
        .shreg      (shreg),
        .operand    (operand),
        .acc_next   (acc_next),
        .shreg_next (shreg_next)
    );

    always_comb begin
        case (op_q)
            MDU_MUL:           fixed = acc_next;
            MDU_DIV, MDU_DIVU: fixed = q_neg ? -shreg_next : shreg_next;
            default:           fixed = r_neg ? -acc_next : acc_next;
        endcase
    end

    assign stall = ((state == IDLE) && start && !flush) || ((state == BUSY) && !flush);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            op_q    <= MDU_MUL;
            acc     <= '0;
            shreg   <= '0;
            operand <= '0;
            count   <= '0;
            q_neg   <= 1'b0;
            r_neg   <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
            end else begin
                case (state)
                    IDLE: if (start) begin
                        op_q    <= op_in;
                        acc     <= '0;
                        // Multiply streams b through shreg and adds a; divide shifts |a| against |b|.
                        shreg   <= in_div ? a_mag : b;
                        operand <= in_div ? b_mag : a;
                        q_neg   <= in_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                        r_neg   <= in_signed && a[WIDTH-1];
                        count   <= '0;
                        if (div_zero || overflow) begin
                            result <= bypass_val;
                            done   <= 1'b1;
                            state  <= DONE;
                        end else begin
                            state <= BUSY;
                        end
                    end
                    BUSY: begin
                        acc   <= acc_next;
                        shreg <= shreg_next;
                        count <= count + 1'b1;
                        if (count == CW'(WIDTH - 1)) begin
                            result <= fixed;
                            done   <= 1'b1;
                            state  <= DONE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
